// File: rtl/vga_syncgen.sv
// vga_syncgen: VGA pixel counters, registered sync/enable decode and frame counter
module vga_syncgen #(
  parameter int H_SYNC_INTERVAL = 800,
  parameter int H_FRONT         = 16,
  parameter int H_WIDTH         = 96,
  parameter int H_BACK          = 48,
  parameter int H_BRANK         = H_FRONT + H_WIDTH + H_BACK,
  parameter int V_SYNC_INTERVAL = 525,
  parameter int V_FRONT         = 10,
  parameter int V_WIDTH         = 2,
  parameter int V_BACK          = 33,
  parameter int V_BRANK         = V_FRONT + V_WIDTH + V_BACK
) (
  input  logic       PCK,
  input  logic       RST,
  output logic [9:0] HCNT,
  output logic [9:0] VCNT,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       DISP_EN,
  output logic       FRAME_START,
  output logic [7:0] FRAME_CNT
);
  localparam logic [9:0] H_LAST  = 10'(H_SYNC_INTERVAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_SYNC_INTERVAL - 1);
  localparam logic [9:0] HS_LO   = 10'(H_FRONT);
  localparam logic [9:0] HS_HI   = 10'(H_FRONT + H_WIDTH);
  localparam logic [9:0] VS_LO   = 10'(V_FRONT);
  localparam logic [9:0] VS_HI   = 10'(V_FRONT + V_WIDTH);
  localparam logic [9:0] H_ACT   = 10'(H_BRANK);
  localparam logic [9:0] V_ACT   = 10'(V_BRANK);
  logic h_end, v_end;
  assign h_end = HCNT == H_LAST;
  assign v_end = VCNT == V_LAST;
  // counters advance every pixel; sync/enable are decoded from the pre-edge counts so they trail by one PCK
  always_ff @(posedge PCK) begin
    if (RST) begin
      HCNT        <= '0;
      VCNT        <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      DISP_EN     <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_CNT   <= '0;
    end else begin
      HCNT        <= h_end ? '0 : HCNT + 10'd1;
      if (h_end) VCNT <= v_end ? '0 : VCNT + 10'd1;
      VGA_HS      <= !(HCNT >= HS_LO && HCNT < HS_HI);
      VGA_VS      <= !(VCNT >= VS_LO && VCNT < VS_HI);
      DISP_EN     <= HCNT >= H_ACT && VCNT >= V_ACT;
      FRAME_START <= h_end && v_end;
      if (h_end && v_end) FRAME_CNT <= FRAME_CNT + 8'd1;
    end
  end
endmodule

// File: tb/tb_vga_syncgen.sv
// tb_vga_syncgen: directed table and sequence checks of the VGA timing generator
module tb_vga_syncgen;
  logic PCK = 1'b0;
  logic RST = 1'b1;
  always #5 PCK = ~PCK;

  logic [9:0] h0, v0, h1, v1, h2, v2;
  logic       hs0, vs0, de0, fs0, hs1, vs1, de1, fs1, hs2, vs2, de2, fs2;
  logic [7:0] fc0, fc1, fc2;

  vga_syncgen d0 (.PCK(PCK), .RST(RST), .HCNT(h0), .VCNT(v0), .VGA_HS(hs0), .VGA_VS(vs0),
                  .DISP_EN(de0), .FRAME_START(fs0), .FRAME_CNT(fc0));

  vga_syncgen #(.H_SYNC_INTERVAL(64), .H_FRONT(4), .H_WIDTH(8), .H_BACK(4), .H_BRANK(16),
                .V_SYNC_INTERVAL(20), .V_FRONT(2), .V_WIDTH(2), .V_BACK(3), .V_BRANK(7))
    d1 (.PCK(PCK), .RST(RST), .HCNT(h1), .VCNT(v1), .VGA_HS(hs1), .VGA_VS(vs1),
        .DISP_EN(de1), .FRAME_START(fs1), .FRAME_CNT(fc1));

  vga_syncgen #(.H_SYNC_INTERVAL(8), .H_FRONT(1), .H_WIDTH(1), .H_BACK(1), .H_BRANK(3),
                .V_SYNC_INTERVAL(4), .V_FRONT(1), .V_WIDTH(1), .V_BACK(1), .V_BRANK(3))
    d2 (.PCK(PCK), .RST(RST), .HCNT(h2), .VCNT(v2), .VGA_HS(hs2), .VGA_VS(vs2),
        .DISP_EN(de2), .FRAME_START(fs2), .FRAME_CNT(fc2));

  typedef struct {
    int c;
    int h;
    int v;
    int hs;
    int vs;
    int de;
  } vec_t;

  vec_t tab[17];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    repeat (3) @(posedge PCK);
    #1;
    RST = 1'b0;
  endtask

  task automatic step();
    @(posedge PCK);
    #1;
  endtask

  initial begin
    int idx, hs_low, herr, vs_low1, de_cnt1, fs_cnt1, fs_bad1, fs_cnt0;
    tab[0]  = '{0,     0,   0,  1, 1, 0};
    tab[1]  = '{1,     1,   0,  1, 1, 0};
    tab[2]  = '{16,    16,  0,  1, 1, 0};
    tab[3]  = '{17,    17,  0,  0, 1, 0};
    tab[4]  = '{112,   112, 0,  0, 1, 0};
    tab[5]  = '{113,   113, 0,  1, 1, 0};
    tab[6]  = '{799,   799, 0,  1, 1, 0};
    tab[7]  = '{800,   0,   1,  1, 1, 0};
    tab[8]  = '{8001,  1,   10, 1, 0, 0};
    tab[9]  = '{8017,  17,  10, 0, 0, 0};
    tab[10] = '{9600,  0,   12, 1, 0, 0};
    tab[11] = '{9601,  1,   12, 1, 1, 0};
    tab[12] = '{36160, 160, 45, 1, 1, 0};
    tab[13] = '{36161, 161, 45, 1, 1, 1};
    tab[14] = '{36799, 799, 45, 1, 1, 1};
    tab[15] = '{36800, 0,   46, 1, 1, 1};
    tab[16] = '{36801, 1,   46, 1, 1, 0};
    idx = 0; hs_low = 0; herr = 0; vs_low1 = 0; de_cnt1 = 0; fs_cnt1 = 0; fs_bad1 = 0; fs_cnt0 = 0;
    reset_dut();
    chk("reset_fc", int'(fc0), 0);
    chk("reset_fs", int'(fs0), 0);
    for (int c = 0; c <= 36801; c++) begin
      if (c > 0) step();
      if (idx < 17 && c == tab[idx].c) begin
        chk($sformatf("hcnt@%0d", c), int'(h0), tab[idx].h);
        chk($sformatf("vcnt@%0d", c), int'(v0), tab[idx].v);
        chk($sformatf("hs@%0d", c), int'(hs0), tab[idx].hs);
        chk($sformatf("vs@%0d", c), int'(vs0), tab[idx].vs);
        chk($sformatf("de@%0d", c), int'(de0), tab[idx].de);
        idx++;
      end
      if (c >= 1 && c <= 800 && !hs0) hs_low++;
      if (c <= 801 && int'(h0) != c % 800) herr++;
      if (fs0 || fc0 != 8'd0) fs_cnt0++;
      if (c >= 1 && c <= 1280) begin
        if (!vs1) vs_low1++;
        if (de1) de_cnt1++;
      end
      if (c >= 1 && c <= 2600 && fs1) begin
        fs_cnt1++;
        if (h1 != 10'd0 || v1 != 10'd0) fs_bad1++;
      end
      if (c == 1279) chk("fc1_before_wrap", int'(fc1), 0);
      if (c == 1280) begin
        chk("fc1_first_wrap", int'(fc1), 1);
        chk("fs1_pulse", int'(fs1), 1);
        chk("de1_last", int'(de1), 1);
      end
      if (c == 1281) begin
        chk("fs1_width", int'(fs1), 0);
        chk("de1_after_last", int'(de1), 0);
      end
      if (c == 2560) chk("fc1_second_wrap", int'(fc1), 2);
      if (c == 464) chk("de1_before_first", int'(de1), 0);
      if (c == 465) chk("de1_first", int'(de1), 1);
      if (c == 8160) chk("fc2_255", int'(fc2), 255);
      if (c == 8192) chk("fc2_wrap0", int'(fc2), 0);
      if (c == 8224) chk("fc2_after", int'(fc2), 1);
    end
    chk("table_entries_hit", idx, 17);
    chk("hs_low_cycles", hs_low, 96);
    chk("hcnt_sequence_errs", herr, 0);
    chk("d0_no_frame_activity", fs_cnt0, 0);
    chk("vs1_low_per_frame", vs_low1, 128);
    chk("de1_per_frame", de_cnt1, 624);
    chk("fs1_pulses", fs_cnt1, 2);
    chk("fs1_not_at_origin", fs_bad1, 0);
    reset_dut();
    repeat (8850) step();
    chk("mid_pre_h", int'(h0), 50);
    chk("mid_pre_v", int'(v0), 11);
    chk("mid_pre_hs", int'(hs0), 0);
    chk("mid_pre_vs", int'(vs0), 0);
    chk("mid_pre_fc1", int'(fc1), 6);
    chk("mid_pre_fc2", int'(fc2), 20);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid_rst_h", int'(h0), 0);
    chk("mid_rst_v", int'(v0), 0);
    chk("mid_rst_hs", int'(hs0), 1);
    chk("mid_rst_vs", int'(vs0), 1);
    chk("mid_rst_de", int'(de0), 0);
    chk("mid_rst_fc1", int'(fc1), 0);
    chk("mid_rst_fc2", int'(fc2), 0);
    step();
    chk("mid_rel_h", int'(h0), 1);
    chk("mid_rel_v", int'(v0), 0);
    chk("mid_rel_hs", int'(hs0), 1);
    chk("mid_rel_vs", int'(vs0), 1);
    step();
    chk("mid_rel_h2", int'(h0), 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
